// File: rtl/instruction_memory_loader_pkg.sv
// instruction_memory_loader_pkg: shared sizes, state encoding and helpers for the loader
package instruction_memory_loader_pkg;

    localparam int DEPTH        = 64;
    localparam int ADDR_W       = 6;
    localparam int DATA_W       = 16;
    localparam int NUM_WR_PORTS = 4;
    localparam int CNT_W        = 7;
    localparam int FILL_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A load request is legal when it asks for at least one word and stays inside the memory
    function automatic logic range_ok(input logic [CNT_W-1:0] count, input int base, input int depth);
        logic [7:0] last;
        last = 8'(base) + {1'b0, count};
        return (count != '0) && (last <= 8'(depth));
    endfunction

endpackage

// File: rtl/instruction_memory_loader_word_packer.sv
// loader_word_packer: pairs big-endian stream bytes into 16-bit instruction words
module loader_word_packer
    import instruction_memory_loader_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic [7:0]        i_byte_data,
    input  logic              i_byte_valid,
    input  logic              i_byte_ready,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);

    logic       r_lo;
    logic [7:0] r_hi_byte;
    logic       w_xfer;

    assign w_xfer       = i_byte_valid & i_byte_ready;
    assign o_word_valid = w_xfer & r_lo;
    assign o_word       = {r_hi_byte, i_byte_data};

    // Track which half of the pair comes next and hold the high byte until its partner arrives
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_lo      <= 1'b0;
            r_hi_byte <= '0;
        end else if (i_clear) begin
            r_lo      <= 1'b0;
        end else if (w_xfer) begin
            r_lo      <= ~r_lo;
            r_hi_byte <= r_lo ? r_hi_byte : i_byte_data;
        end
    end

endmodule

// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: fills instruction memory from a byte stream in bursts of up to four words
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_word_count,
    input  logic [7:0]        i_byte_data,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic [ADDR_W-1:0] o_instruction_wr1,
    output logic [ADDR_W-1:0] o_instruction_wr2,
    output logic [ADDR_W-1:0] o_instruction_wr3,
    output logic [ADDR_W-1:0] o_instruction_wr4,
    output logic [DATA_W-1:0] o_instruction_wr1_data,
    output logic [DATA_W-1:0] o_instruction_wr2_data,
    output logic [DATA_W-1:0] o_instruction_wr3_data,
    output logic [DATA_W-1:0] o_instruction_wr4_data,
    output logic              o_instruction_wr1_enable,
    output logic              o_instruction_wr2_enable,
    output logic              o_instruction_wr3_enable,
    output logic              o_instruction_wr4_enable,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_received;
    logic [FILL_W-1:0] r_fill;
    logic [ADDR_W:0]   r_next_addr;
    logic [DATA_W-1:0] r_slot [NUM_WR_PORTS];
    logic              r_error;
    logic              w_range_ok;
    logic              w_accept;
    logic              w_byte_ready;
    logic [DATA_W-1:0] w_word;
    logic              w_word_valid;
    logic              w_burst_full;
    logic              w_wr_en   [NUM_WR_PORTS];
    logic [ADDR_W-1:0] w_wr_addr [NUM_WR_PORTS];
    logic [DATA_W-1:0] w_wr_data [NUM_WR_PORTS];

    assign w_range_ok   = range_ok(i_word_count, BASE_ADDR, DEPTH);
    assign w_accept     = (r_state == IDLE) && i_start && w_range_ok;
    assign w_burst_full = (r_fill == FILL_W'(NUM_WR_PORTS - 1)) || (r_received + 1'b1 == r_count);

    loader_word_packer u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (w_accept),
        .i_byte_data  (i_byte_data),
        .i_byte_valid (i_byte_valid),
        .i_byte_ready (w_byte_ready),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Next state: a burst closes on the fourth word or on the last word of the load
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? RECV : IDLE;
            RECV:    w_next_state = (w_word_valid && w_burst_full) ? WRITE : RECV;
            WRITE:   w_next_state = (r_received == r_count) ? DONE : RECV;
            default: w_next_state = IDLE;
        endcase
    end

    // Load bookkeeping: latch the request, collect words into slots, advance the address after a burst
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count     <= '0;
            r_received  <= '0;
            r_fill      <= '0;
            r_next_addr <= '0;
            r_error     <= 1'b0;
            for (int k = 0; k < NUM_WR_PORTS; k++)
                r_slot[k] <= '0;
        end else begin
            r_error <= (r_state == IDLE) && i_start && !w_range_ok;
            if (w_accept) begin
                r_count     <= i_word_count;
                r_received  <= '0;
                r_fill      <= '0;
                r_next_addr <= (ADDR_W+1)'(BASE_ADDR);
            end else if (r_state == RECV && w_word_valid) begin
                r_slot[r_fill[1:0]] <= w_word;
                r_fill              <= r_fill + 1'b1;
                r_received          <= r_received + 1'b1;
            end else if (r_state == WRITE) begin
                r_next_addr <= r_next_addr + (ADDR_W+1)'(r_fill);
                r_fill      <= '0;
            end
        end
    end

    // Outputs: handshake and status from state; only the filled slots drive write ports during WRITE
    always_comb begin
        w_byte_ready = (r_state == RECV);
        o_busy       = (r_state != IDLE);
        o_done       = (r_state == DONE);
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            w_wr_en[k]   = (r_state == WRITE) && (FILL_W'(k) < r_fill);
            w_wr_addr[k] = w_wr_en[k] ? ADDR_W'(r_next_addr + (ADDR_W+1)'(k)) : '0;
            w_wr_data[k] = w_wr_en[k] ? r_slot[k] : '0;
        end
    end

    assign o_byte_ready             = w_byte_ready;
    assign o_error                  = r_error;
    assign o_instruction_wr1        = w_wr_addr[0];
    assign o_instruction_wr2        = w_wr_addr[1];
    assign o_instruction_wr3        = w_wr_addr[2];
    assign o_instruction_wr4        = w_wr_addr[3];
    assign o_instruction_wr1_data   = w_wr_data[0];
    assign o_instruction_wr2_data   = w_wr_data[1];
    assign o_instruction_wr3_data   = w_wr_data[2];
    assign o_instruction_wr4_data   = w_wr_data[3];
    assign o_instruction_wr1_enable = w_wr_en[0];
    assign o_instruction_wr2_enable = w_wr_en[1];
    assign o_instruction_wr3_enable = w_wr_en[2];
    assign o_instruction_wr4_enable = w_wr_en[3];

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
Boot/debug loader that fills the 64 x 16-bit instruction memory from an external byte stream, e.g. a UART or JTAG bridge. It accepts bytes over a valid/ready handshake and packs byte pairs into 16-bit instruction words. Up to four words are buffered and then burst-written in a single cycle through the instruction memory's four write ports. The loader is the writer side of those write ports and replaces the memory's hard-coded reset image at bring-up.

Parameters:
DEPTH, 64, number of instruction memory words
ADDR_W, 6, instruction memory address width
DATA_W, 16, instruction word width
BASE_ADDR, 0, first memory address written by each load

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
word_count  input  7  number of words to load, 1..64; latched on accepted start
byte_data  input  8  incoming stream byte
byte_valid  input  1  byte_data is valid
byte_ready  output  1  loader accepts a byte this cycle
instruction_wr1..4  output  ADDR_W each  write addresses for ports 1..4
instruction_wr1..4_data  output  DATA_W each  write data for ports 1..4
instruction_wr1..4_enable  output  1 each  write strobes for ports 1..4
busy  output  1  high from the cycle after an accepted start through the DONE state
done  output  1  one-cycle pulse when the load completes
error  output  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - Every output goes to 0.
  - State goes to IDLE.
  - Internal counters, word slots and the hi/lo byte flag are cleared.
  - A reset mid-load discards any partial word or burst; no write enable is asserted.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready=0.
  - On start=1, valid means word_count>=1 and BASE_ADDR+word_count<=DEPTH.
  - If valid: latch count, set next_addr=BASE_ADDR, received=0, fill=0, hi=1, then go to RECV.
  - If invalid: error=1 for the next cycle only and stay in IDLE.
- RECV:
  - byte_ready=1; a byte transfers on byte_valid & byte_ready.
  - Bytes are big-endian: the first byte of a pair is bits 15:8, the second is bits 7:0.
  - On the second byte, the word goes into slot[fill], then fill+1 and received+1.
  - Transition to WRITE when fill reaches 4 or received reaches count.
  - Throughput is 1 byte per cycle; gaps in byte_valid are allowed anywhere, including between the two bytes of a word.
- WRITE (exactly one cycle):
  - byte_ready=0.
  - For k < fill: instruction_wr(k+1)=next_addr+k, data=slot[k], enable=1.
  - Ports at or above fill keep enable=0.
  - Then next_addr += fill and fill=0.
  - Go to DONE if received==count, else back to RECV.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- start is ignored while not in IDLE.
- Latency:
  - Last byte of a burst accepted in cycle N: write enables in N+1.
  - If that was the last word: done in N+2 and byte_ready=0 from N+1 onward.
- Addresses never wrap, because the range is checked at start.
- The four ports in one burst always carry distinct addresses, so write-order collisions inside the memory cannot occur.
- Address and data outputs may hold stale values when enable=0; the verifier must check them only under enable.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/RECV/WRITE/DONE
  - DEPTH, ADDR_W, DATA_W
  - write-port count constant NUM_WR_PORTS=4
- Natural sub-module: loader_word_packer. It takes the byte handshake and hi/lo flag and emits a 16-bit word plus a one-cycle word_valid. The top-level FSM owns the slots, counters and write ports.

Test Plan:
1. start, count=4, bytes 01 00 02 00 03 00 04 00 -> one cycle with all four enables, addrs 0,1,2,3, data 0x0100,0x0200,0x0300,0x0400; done exactly 2 cycles after the last byte; busy drops after done.
2. count=5, bytes for words 0x1111..0x5555 -> burst 1 writes addrs 0..3; burst 2 asserts only wr1_enable, addr 4, data 0x5555; wr2..4_enable stay 0; one done pulse.
3. count=4 with byte_valid toggling 1/0 each cycle -> same writes as scenario 1; byte_ready=0 during the WRITE cycle; no byte lost or duplicated.
4. start with count=0, then start with count=65 -> error pulse 1 cycle each; busy, byte_ready and all enables stay 0.
5. count=4, reset driven low after 3 bytes accepted -> all outputs 0 immediately with no enable pulse; after reset release, a new load with count=1 and bytes AB CD writes 0xABCD to addr 0.
6. count=64 with incrementing data 0x0000..0x003F -> 16 WRITE bursts, the final one addrs 60..63 with data 0x003C..0x003F; done pulse; start asserted mid-load is ignored.
